// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled mid-bit sampling with falling-edge start detection,
// false-start rejection and stop-bit framing check.
module uart_rx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int OS_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int CNT_W  = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
    localparam int IDX_W  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OS_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MID  = IDX_W'(OVERSAMPLE / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic              rx_m;
    logic              rx_s;
    logic              rx_d;

    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    logic              tick;

    logic [2:0]        bit_cnt;
    logic [7:0]        shreg;

    logic              timing_clr;
    logic              idx_clr;
    logic              shift_en;
    logic              stop_ok;
    logic              stop_bad;

    function automatic logic [IDX_W-1:0] idx_next(input logic [IDX_W-1:0] cur);
        idx_next = (cur == IDX_LAST) ? '0 : cur + 1'b1;
    endfunction

    // Stage: two-flop synchronizer plus one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    assign tick = (cnt == CNT_LAST);

    // Stage: oversample tick generator and tick index within the current bit
    always_ff @(posedge clk) begin
        if (rst || timing_clr) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (idx_clr) begin
                idx <= '0;
            end else if (tick) begin
                idx <= idx_next(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        timing_clr = 1'b0;
        idx_clr    = 1'b0;
        shift_en   = 1'b0;
        stop_ok    = 1'b0;
        stop_bad   = 1'b0;
        case (state)
            IDLE: begin
                if (rx_d && !rx_s) begin
                    state_nxt  = START;
                    timing_clr = 1'b1;
                end
            end
            START: begin
                if (tick && idx == IDX_MID) begin
                    if (!rx_s) begin
                        state_nxt = DATA;
                        idx_clr   = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (tick && idx == IDX_LAST) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                // Leave immediately after the mid-stop sample so a start edge in
                // the second half of the stop bit is caught.
                if (tick && idx == IDX_LAST) begin
                    state_nxt = IDLE;
                    stop_ok   = rx_s;
                    stop_bad  = !rx_s;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage: data shift register and bit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            if (idx_clr) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (shift_en) begin
                shreg <= {rx_s, shreg[7:1]};
            end
        end
    end

    // Stage: registered outputs, one clk after the mid-stop sample
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= stop_ok;
            frame_err <= stop_bad;
            if (stop_ok) begin
                rx_data <= shreg;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames driven from a bit-level line model,
// received bytes and error pulses compared against an expected-frame queue.
module tb_uart_rx;

    localparam int CLK_FREQ   = 1_600_000;
    localparam int BAUD_RATE  = 10_000;
    localparam int OVERSAMPLE = 16;
    localparam int BIT_CLK    = CLK_FREQ / BAUD_RATE;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] got_q[$];
    int         vld_cnt  = 0;
    int         fe_cnt   = 0;
    int         both_cnt = 0;
    int         wide_cnt = 0;
    logic       prev_v   = 1'b0;
    logic       prev_f   = 1'b0;
    logic [7:0] last_good = 8'h00;

    uart_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .OVERSAMPLE(OVERSAMPLE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            got_q.push_back(rx_data);
            vld_cnt++;
        end
        if (frame_err === 1'b1) fe_cnt++;
        if (rx_valid === 1'b1 && frame_err === 1'b1) both_cnt++;
        if ((rx_valid === 1'b1 && prev_v) || (frame_err === 1'b1 && prev_f)) wide_cnt++;
        prev_v = (rx_valid === 1'b1);
        prev_f = (frame_err === 1'b1);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input int per, input logic stop_v);
        rx = 1'b0;
        repeat (per) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (per) @(negedge clk);
        end
        rx = stop_v;
        repeat (per) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx  = 1'b1;
        idle(3);
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data: got %0h want 00", rx_data); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        idle(20);
        last_good = 8'h00;
    endtask

    task automatic test_single;
        int lat = -1;
        logic busy_mid = 1'b0;
        logic busy_at = 1'b1;
        int v0 = vld_cnt;
        int f0 = fe_cnt;
        got_q.delete();
        fork
            send_frame(8'hA5, BIT_CLK, 1'b1);
            begin
                for (int i = 1; i <= 2000; i++) begin
                    @(negedge clk);
                    if (i == 800) busy_mid = busy;
                    if (rx_valid === 1'b1 && lat < 0) begin
                        lat = i;
                        busy_at = busy;
                    end
                end
            end
        join
        last_good = 8'hA5;
        total++; if (vld_cnt - v0 != 1) begin bad++; $display("FAIL single_pulses: got %0d want 1", vld_cnt - v0); end
        total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL single_data: got %0h want a5", rx_data); end
        total++; if (fe_cnt != f0) begin bad++; $display("FAIL single_frame_err: got %0d want 0", fe_cnt - f0); end
        total++; if (lat < 1522 || lat > 1526) begin bad++; $display("FAIL single_latency: got %0d want 1522..1526", lat); end
        total++; if (busy_mid !== 1'b1) begin bad++; $display("FAIL single_busy_mid: got %b want 1", busy_mid); end
        total++; if (busy_at !== 1'b0) begin bad++; $display("FAIL single_busy_after_stop: got %b want 0", busy_at); end
    endtask

    task automatic test_back_to_back;
        int f0 = fe_cnt;
        got_q.delete();
        send_frame(8'h00, BIT_CLK, 1'b1);
        send_frame(8'hFF, BIT_CLK, 1'b1);
        idle(2 * BIT_CLK);
        last_good = 8'hFF;
        total++;
        if (got_q.size() != 2) begin
            bad++; $display("FAIL b2b_count: got %0d want 2", got_q.size());
        end else begin
            if (got_q[0] !== 8'h00) begin bad++; $display("FAIL b2b_first: got %0h want 00", got_q[0]); end
            total++;
            if (got_q[1] !== 8'hFF) begin bad++; $display("FAIL b2b_second: got %0h want ff", got_q[1]); end
        end
        total++; if (fe_cnt != f0) begin bad++; $display("FAIL b2b_frame_err: got %0d want 0", fe_cnt - f0); end
    endtask

    task automatic test_false_start;
        int busy_cyc = 0;
        int v0 = vld_cnt;
        int f0 = fe_cnt;
        rx = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (i == 40) rx = 1'b1;
            if (busy === 1'b1) busy_cyc++;
        end
        total++; if (busy_cyc < 76 || busy_cyc > 84) begin bad++; $display("FAIL false_start_busy_len: got %0d want 76..84", busy_cyc); end
        total++; if (vld_cnt != v0 || fe_cnt != f0) begin bad++; $display("FAIL false_start_pulses: got v=%0d f=%0d want 0 0", vld_cnt - v0, fe_cnt - f0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL false_start_busy_end: got %b want 0", busy); end
        got_q.delete();
        send_frame(8'h3C, BIT_CLK, 1'b1);
        idle(BIT_CLK);
        last_good = 8'h3C;
        total++;
        if (got_q.size() != 1 || got_q[0] !== 8'h3C) begin
            bad++; $display("FAIL after_false_start_data: got n=%0d d=%0h want n=1 d=3c", got_q.size(), rx_data);
        end
    endtask

    task automatic test_frame_err;
        int v0 = vld_cnt;
        int f0 = fe_cnt;
        send_frame(8'h55, BIT_CLK, 1'b0);
        idle(2 * BIT_CLK);
        total++; if (fe_cnt - f0 != 1) begin bad++; $display("FAIL ferr_pulses: got %0d want 1", fe_cnt - f0); end
        total++; if (vld_cnt != v0) begin bad++; $display("FAIL ferr_valid: got %0d want 0", vld_cnt - v0); end
        total++; if (rx_data !== last_good) begin bad++; $display("FAIL ferr_data_kept: got %0h want %0h", rx_data, last_good); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] b = 8'hE7;
        int v0 = vld_cnt;
        int f0 = fe_cnt;
        rx = 1'b0;
        idle(BIT_CLK);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            idle(BIT_CLK);
        end
        rx = b[4];
        idle(BIT_CLK / 2);
        rst = 1'b1;
        idle(1);
        last_good = 8'h00;
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL midrst_rx_data: got %0h want 00", rx_data); end
        total++; if (rx_valid !== 1'b0 || frame_err !== 1'b0) begin bad++; $display("FAIL midrst_pulses: got v=%b f=%b want 0 0", rx_valid, frame_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        idle(BIT_CLK / 2 - 1);
        for (int i = 5; i < 8; i++) begin
            rx = b[i];
            idle(BIT_CLK);
        end
        rx = 1'b1;
        idle(BIT_CLK);
        idle(5);
        rst = 1'b0;
        idle(2 * BIT_CLK);
        total++; if (vld_cnt != v0 || fe_cnt != f0) begin bad++; $display("FAIL midrst_no_pulse: got v=%0d f=%0d want 0 0", vld_cnt - v0, fe_cnt - f0); end
        got_q.delete();
        send_frame(8'h81, BIT_CLK, 1'b1);
        idle(BIT_CLK);
        last_good = 8'h81;
        total++;
        if (got_q.size() != 1 || got_q[0] !== 8'h81) begin
            bad++; $display("FAIL midrst_next_frame: got n=%0d d=%0h want n=1 d=81", got_q.size(), rx_data);
        end
    endtask

    task automatic test_baud_tol;
        int pers[2] = '{155, 165};
        for (int k = 0; k < 2; k++) begin
            got_q.delete();
            send_frame(8'hC3, pers[k], 1'b1);
            idle(BIT_CLK);
            last_good = 8'hC3;
            total++;
            if (got_q.size() != 1 || got_q[0] !== 8'hC3) begin
                bad++; $display("FAIL baud_tol_%0d: got n=%0d d=%0h want n=1 d=c3", pers[k], got_q.size(), rx_data);
            end
        end
    endtask

    task automatic test_random;
        logic [7:0] exp_q[$];
        int exp_fe = 0;
        int f0 = fe_cnt;
        got_q.delete();
        for (int n = 0; n < 8; n++) begin
            logic [7:0] b;
            int per;
            logic stop_v;
            b      = 8'($urandom);
            per    = $urandom_range(155, 165);
            stop_v = ($urandom_range(0, 3) != 0);
            send_frame(b, per, stop_v);
            if (stop_v) begin
                exp_q.push_back(b);
                last_good = b;
                idle($urandom_range(0, 100));
            end else begin
                exp_fe++;
                idle(20 + $urandom_range(0, 100));
            end
        end
        idle(2 * BIT_CLK);
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++; $display("FAIL random_count: got %0d want %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL random_byte_%0d: got %0h want %0h", i, got_q[i], exp_q[i]); end
            end
        end
        total++; if (fe_cnt - f0 != exp_fe) begin bad++; $display("FAIL random_frame_err: got %0d want %0d", fe_cnt - f0, exp_fe); end
        total++; if (rx_data !== last_good) begin bad++; $display("FAIL random_last_data: got %0h want %0h", rx_data, last_good); end
    endtask

    task automatic test_pulse_rules;
        total++; if (both_cnt != 0) begin bad++; $display("FAIL pulse_overlap: got %0d want 0", both_cnt); end
        total++; if (wide_cnt != 0) begin bad++; $display("FAIL pulse_width: got %0d want 0", wide_cnt); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_false_start;
        test_frame_err;
        test_reset_mid;
        test_baud_tol;
        test_random;
        test_pulse_rules;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
